// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device transmitter (request-to-send sequence).
// Sends one command byte to a PS/2 device, driving the open-drain lines via
// output enables (pad tristates live in the top level).
// Ports:
//   clk, resetn          system clock, asynchronous active-low reset
//   tx_valid/tx_data     command byte offer; accepted when tx_valid && tx_ready
//   tx_ready             high only while idle
//   ps2_clk, ps2_data    raw (asynchronous) PS/2 line levels
//   ps2_clk_oe/data_oe   1 = pull the line low, 0 = release
//   busy                 high while the transmitter owns the bus
//   done                 one-cycle pulse at the end of every transfer
//   ack_ok               valid with done: device acknowledged the byte
//   err_timeout          one-cycle pulse with done when the transfer timed out
`timescale 1ns/1ps
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_ok,
  output logic       err_timeout
);

  localparam int unsigned IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

  // FINISH holds the registered done pulse so tx_ready rises the cycle after.
  typedef enum logic [2:0] {
    IDLE, INHIBIT, RELEASE, SEND, ACK, WAIT_IDLE, FINISH
  } state_t;

  state_t        state, state_n;
  logic [2:0]    clk_sync, data_sync;
  logic          clk_prev;
  logic          fall;
  logic [IW-1:0] inh_cnt, inh_cnt_n;
  logic [TW-1:0] to_cnt, to_cnt_n;
  logic [3:0]    bit_idx, bit_idx_n;
  logic [7:0]    byte_q, byte_n;
  logic          parity_q, parity_n;
  logic          ack_q, ack_n;
  logic          clk_oe_q, clk_oe_n;
  logic          data_oe_q, data_oe_n;
  logic          done_q, done_n;
  logic          ack_ok_q, ack_ok_n;
  logic          err_q, err_n;

  assign fall        = clk_prev & ~clk_sync[2];
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign done        = done_q;
  assign ack_ok      = ack_ok_q;
  assign err_timeout = err_q;
  assign tx_ready    = (state == IDLE);
  assign busy        = (state != IDLE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      clk_sync  <= '1;
      data_sync <= '1;
      clk_prev  <= 1'b1;
      inh_cnt   <= '0;
      to_cnt    <= '0;
      bit_idx   <= '0;
      byte_q    <= '0;
      parity_q  <= 1'b0;
      ack_q     <= 1'b0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      done_q    <= 1'b0;
      ack_ok_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state     <= state_n;
      clk_sync  <= {clk_sync[1:0], ps2_clk};
      data_sync <= {data_sync[1:0], ps2_data};
      clk_prev  <= clk_sync[2];
      inh_cnt   <= inh_cnt_n;
      to_cnt    <= to_cnt_n;
      bit_idx   <= bit_idx_n;
      byte_q    <= byte_n;
      parity_q  <= parity_n;
      ack_q     <= ack_n;
      clk_oe_q  <= clk_oe_n;
      data_oe_q <= data_oe_n;
      done_q    <= done_n;
      ack_ok_q  <= ack_ok_n;
      err_q     <= err_n;
    end
  end

  always_comb begin
    state_n   = state;
    inh_cnt_n = inh_cnt;
    to_cnt_n  = to_cnt;
    bit_idx_n = bit_idx;
    byte_n    = byte_q;
    parity_n  = parity_q;
    ack_n     = ack_q;
    clk_oe_n  = clk_oe_q;
    data_oe_n = data_oe_q;
    done_n    = 1'b0;
    ack_ok_n  = 1'b0;
    err_n     = 1'b0;

    unique case (state)
      IDLE: begin
        clk_oe_n  = 1'b0;
        data_oe_n = 1'b0;
        if (tx_valid) begin
          byte_n    = tx_data;
          parity_n  = ~^tx_data;
          inh_cnt_n = '0;
          clk_oe_n  = 1'b1;
          state_n   = INHIBIT;
        end
      end
      INHIBIT: begin
        if (inh_cnt == INH_LAST) begin
          data_oe_n = 1'b1;               // start bit
          state_n   = RELEASE;
        end else begin
          inh_cnt_n = inh_cnt + IW'(1);
        end
      end
      RELEASE: begin
        clk_oe_n  = 1'b0;
        bit_idx_n = '0;
        to_cnt_n  = '0;
        state_n   = SEND;
      end
      SEND, ACK, WAIT_IDLE: begin
        to_cnt_n = fall ? '0 : to_cnt + TW'(1);
        if (!fall && to_cnt == TO_LAST) begin
          clk_oe_n  = 1'b0;
          data_oe_n = 1'b0;
          done_n    = 1'b1;
          err_n     = 1'b1;
          state_n   = FINISH;
        end else if (state == SEND) begin
          if (fall) begin
            if (bit_idx < 4'd8) begin
              data_oe_n = ~byte_q[bit_idx[2:0]];
            end else if (bit_idx == 4'd8) begin
              data_oe_n = ~parity_q;
            end else begin
              data_oe_n = 1'b0;           // stop bit: line released
              state_n   = ACK;
            end
            bit_idx_n = bit_idx + 4'd1;
          end
        end else if (state == ACK) begin
          if (fall) begin
            ack_n   = ~data_sync[2];
            state_n = WAIT_IDLE;
          end
        end else begin
          if (clk_sync[2] && data_sync[2]) begin
            done_n   = 1'b1;
            ack_ok_n = ack_q;
            state_n  = FINISH;
          end
        end
      end
      FINISH: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed bench for ps2_host_tx with a simple PS/2 device
// model (40-cycle clock period) on a wired-AND bus.
`timescale 1ns/1ps
module tb_ps2_host_tx;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = '0;
  logic       tx_ready;
  logic       ps2_clk_oe, ps2_data_oe;
  logic       busy, done, ack_ok, err_timeout;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;
  logic       bus_clk, bus_data;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int last_fall_cyc = 0;

  assign bus_clk  = ~(ps2_clk_oe | dev_clk_low);
  assign bus_data = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(.INHIBIT_CYCLES(20), .TIMEOUT_CYCLES(200)) dut (
    .clk(clk), .resetn(resetn), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .ps2_clk(bus_clk), .ps2_data(bus_data),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe), .busy(busy),
    .done(done), .ack_ok(ack_ok), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Offer a byte for one cycle (accept), then count cycles with ps2_clk_oe high.
  task automatic start_tx(input logic [7:0] d, output int inh);
    tx_valid = 1'b1;
    tx_data  = d;
    tick();
    tx_valid = 1'b0;
    inh = 0;
    while (ps2_clk_oe && inh < 100) begin
      inh++;
      tick();
    end
  endtask

  // Device side after clock release: bit 0 of frame is the start bit seen at
  // release, bits 1..10 are seen on the rising edges after falls 1..10.
  task automatic dev_run(input int nfalls, input bit do_ack, output logic [10:0] frame);
    frame = '0;
    frame[0] = bus_data;
    repeat (20) tick();
    for (int i = 1; i <= nfalls; i++) begin
      dev_clk_low = 1'b1;
      last_fall_cyc = cyc;
      repeat (20) tick();
      dev_clk_low = 1'b0;
      if (i <= 10) frame[i] = bus_data;
      if (i == nfalls) begin
        dev_data_low = 1'b0;
        break;
      end
      if (do_ack && i == 10) begin
        repeat (10) tick();
        dev_data_low = 1'b1;
        repeat (10) tick();
      end else begin
        repeat (20) tick();
      end
    end
  endtask

  task automatic wait_done(input int budget, output bit got);
    int n = 0;
    while (!done && n < budget) begin
      tick();
      n++;
    end
    got = done;
  endtask

  logic [10:0] frame;
  int          inh;
  bit          got;
  bit          seen;
  bit          bp_stop;
  int          early;

  initial begin
    // reset
    repeat (3) tick();
    check("rst_tx_ready", tx_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ack_ok", ack_ok, 0);
    check("rst_err", err_timeout, 0);
    check("rst_clk_oe", ps2_clk_oe, 0);
    check("rst_data_oe", ps2_data_oe, 0);
    resetn = 1'b1;
    repeat (5) tick();

    // 0xED with ACK
    start_tx(8'hED, inh);
    check("ed_inhibit_len", inh, 21);
    dev_run(11, 1'b1, frame);
    check("ed_frame", frame, 11'b11111011010);
    wait_done(50, got);
    check("ed_done", got, 1);
    check("ed_ack_ok", ack_ok, 1);
    check("ed_err", err_timeout, 0);
    check("ed_ready_in_done", tx_ready, 0);
    tick();
    check("ed_ready_after", tx_ready, 1);
    check("ed_done_width", done, 0);
    repeat (5) tick();

    // 0x01 without ACK
    start_tx(8'h01, inh);
    dev_run(11, 1'b0, frame);
    check("x01_frame", frame, 11'b10000000010);
    wait_done(50, got);
    check("x01_done", got, 1);
    check("x01_ack_ok", ack_ok, 0);
    check("x01_err", err_timeout, 0);
    repeat (5) tick();

    // device never clocks
    start_tx(8'h55, inh);
    repeat (199) tick();
    check("noclk_pre_done", done, 0);
    check("noclk_pre_data_oe", ps2_data_oe, 1);
    tick();
    check("noclk_done", done, 1);
    check("noclk_err", err_timeout, 1);
    check("noclk_ack_ok", ack_ok, 0);
    check("noclk_clk_oe", ps2_clk_oe, 0);
    check("noclk_data_oe", ps2_data_oe, 0);
    tick();
    check("noclk_ready_next", tx_ready, 1);
    repeat (5) tick();

    // device stops after 4 falls: 3 sync flops + edge register + 200
    start_tx(8'hA5, inh);
    dev_run(4, 1'b0, frame);
    wait_done(400, got);
    check("stall_done", got, 1);
    check("stall_delay", cyc - last_fall_cyc, 204);
    check("stall_err", err_timeout, 1);
    check("stall_ack_ok", ack_ok, 0);
    check("stall_lines", {ps2_clk_oe, ps2_data_oe}, 0);
    repeat (5) tick();
    start_tx(8'hFF, inh);
    dev_run(11, 1'b1, frame);
    check("ff_frame", frame, 11'b11111111110);
    wait_done(50, got);
    check("ff_done", got, 1);
    check("ff_ack_ok", ack_ok, 1);
    repeat (5) tick();

    // reset during SEND bit 3
    start_tx(8'hC3, inh);
    dev_run(3, 1'b0, frame);
    check("mid_busy", busy, 1);
    @(negedge clk);
    resetn = 1'b0;
    #1;
    check("mid_clk_oe", ps2_clk_oe, 0);
    check("mid_data_oe", ps2_data_oe, 0);
    check("mid_busy_rst", busy, 0);
    seen = done;
    repeat (3) begin
      tick();
      seen = seen | done;
    end
    resetn = 1'b1;
    tick();
    seen = seen | done;
    check("mid_no_done", seen, 0);
    check("mid_ready", tx_ready, 1);
    repeat (5) tick();

    // back-pressure: tx_valid held, tx_data churning during the transfer
    bp_stop = 1'b0;
    early = 0;
    tx_valid = 1'b1;
    tx_data = 8'h3C;
    tick();
    fork
      begin
        inh = 0;
        while (ps2_clk_oe && inh < 100) begin
          inh++;
          tick();
        end
        dev_run(11, 1'b1, frame);
        wait_done(50, got);
        bp_stop = 1'b1;
        check("bp_frame", frame, 11'b11001111000);
        check("bp_done", got, 1);
        check("bp_ack_ok", ack_ok, 1);
        tick();
        check("bp_ready_after", tx_ready, 1);
        tick();
        check("bp_reaccept", busy, 1);
      end
      begin
        for (int k = 0; k < 3000 && !bp_stop; k++) begin
          tick();
          if (!bp_stop) begin
            if (tx_ready) early++;
            tx_data = 8'($urandom);
          end
        end
      end
    join
    check("bp_no_early_accept", early, 0);
    tx_valid = 1'b0;
    resetn = 1'b0;
    repeat (2) tick();
    resetn = 1'b1;
    repeat (2) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter. It is the send side that pairs with the existing ps2_keyboard receiver.
- Sends one command byte to the keyboard (for example 0xED set-LEDs, 0xFF reset) using the PS/2 host request-to-send sequence.
- Drives the open-drain ps2_clk/ps2_data lines through output-enable signals. The pad-level tristate lives in top.
- Asserts busy while it owns the bus, so top can gate the receiver during a transmission.

Parameters:
- INHIBIT_CYCLES, 5000: clk cycles ps2_clk is held low before the start bit (100 us at 50 MHz).
- TIMEOUT_CYCLES, 1000000: maximum clk cycles between consecutive device clock falling edges, counted from clock release onward (20 ms at 50 MHz).

Ports:
- clk  in  1  system clock; the only clock.
- resetn  in  1  reset, asynchronous, active-low.
- tx_valid  in  1  command byte offered.
- tx_data  in  8  command byte.
- tx_ready  out  1  high only in IDLE; a byte is accepted when tx_valid&&tx_ready.
- ps2_clk  in  1  raw PS/2 clock line (asynchronous).
- ps2_data  in  1  raw PS/2 data line (asynchronous).
- ps2_clk_oe  out  1  1 = pull ps2_clk low; 0 = release.
- ps2_data_oe  out  1  1 = pull ps2_data low; 0 = release.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a transfer ends, whether it succeeded or failed.
- ack_ok  out  1  valid with done: 1 = device ACKed the byte.
- err_timeout  out  1  one-cycle pulse, coincident with done, when a transfer is aborted by timeout.

Behaviour:
- Reset:
  - resetn low releases both lines immediately: ps2_clk_oe=0, ps2_data_oe=0.
  - Outputs: tx_ready=1, busy=0, done=0, ack_ok=0, err_timeout=0.
  - State = IDLE; all counters cleared. This applies in every state, including mid-transfer.
- Input synchronisation:
  - ps2_clk and ps2_data each pass through a 3-flop synchroniser.
  - fall = previous synced clock 1 and current synced clock 0.
- Accept: on accept, latch tx_data and parity = ~^tx_data (odd parity). Go to INHIBIT.
- INHIBIT:
  - ps2_clk_oe=1, ps2_data_oe=0 for INHIBIT_CYCLES cycles.
  - On the final cycle, ps2_data_oe goes to 1 (start bit 0). Go to RELEASE.
- RELEASE: one cycle with ps2_clk_oe=1, ps2_data_oe=1. Then ps2_clk_oe=0; bit index n=0; clear the timeout counter; go to SEND.
- SEND (device clocks; host changes data on falling edges):
  - fall with n=0..7: ps2_data_oe = ~data[n] (LSB first).
  - fall with n=8: ps2_data_oe = ~parity.
  - fall with n=9: ps2_data_oe=0 (stop bit, line released); go to ACK.
  - n increments on each fall.
- ACK:
  - On the next fall, sample synced ps2_data; ack_ok_reg = (ps2_data==0).
  - Go to WAIT_IDLE.
- WAIT_IDLE:
  - Wait until synced ps2_clk and ps2_data are both 1.
  - Then pulse done for one cycle with ack_ok = ack_ok_reg.
  - Go to IDLE; tx_ready returns to 1 on the cycle after the done pulse.
- Timeout:
  - In SEND, ACK and WAIT_IDLE, a counter increments every cycle and clears on each fall.
  - When it reaches TIMEOUT_CYCLES: release both lines in the same cycle, pulse done and err_timeout, set ack_ok=0, go to IDLE.
- tx_valid in non-IDLE states is ignored; tx_data is not re-sampled.
- A fall during INHIBIT/RELEASE is ignored because the host is driving the clock.
- Registered outputs only. ps2_clk_oe and ps2_data_oe are never combinational from the inputs.
- Latency from accept to done, with no stalls: INHIBIT_CYCLES + 1 + 11 device clock periods + sync delay (3 cycles) + wait-idle time.

Test Plan:
- Bench settings: INHIBIT_CYCLES=20, TIMEOUT_CYCLES=200; device model clock period 40 cycles.
- Send 0xED, device ACKs:
  - ps2_clk_oe=1 for 21 cycles after accept.
  - Sampled data bits on device rising edges: 0 (start), 1,0,1,1,0,1,1,1, parity 1, stop 1.
  - done pulse with ack_ok=1, err_timeout=0.
- Send 0x01:
  - parity bit 0, so ps2_data_oe=1 during the parity slot.
  - Device withholds ACK (data stays high): done with ack_ok=0, err_timeout=0.
- Device never clocks after RELEASE:
  - 200 cycles after clock release, ps2_clk_oe=0, ps2_data_oe=0.
  - done=1, err_timeout=1, ack_ok=0; tx_ready=1 on the next cycle.
- Device stops after 4 falls:
  - Timeout fires 200 cycles after the 4th fall; lines released.
  - A second tx_valid with 0xFF then completes with ack_ok=1.
- Reset mid-operation:
  - Drop resetn during SEND bit 3: both oe signals go to 0 asynchronously, busy=0, no done pulse.
  - After resetn rises, tx_ready=1.
- Back-pressure:
  - Holding tx_valid=1 with a changing tx_data during a transfer has no effect.
  - The byte transmitted is the one present at the accept cycle.
  - The next accept occurs only after done.
